bcd_to_binary: RTL and testbench

Sequential BCD-to-binary converter for the Fitbit display/data path: takes four packed BCD digits (0000–9999) and returns the equivalent 14-bit binary value. It uses reverse double-dabble, one bit per clock. It is the inverse of the existing `binaryToBCD` block, so values entered or stored as decimal digits can be fed back into binary arithmetic (step goals, distance counters). A start/busy/done handshake lets the control FSM launch one conversion at a time.

---
 rtl/bcd_pkg.sv | 34 +++
 rtl/bcd_digit_adjust.sv | 26 ++
 rtl/bcd_to_binary.sv | 170 +++++++++++++++++
 tb/tb_bcd_to_binary.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_pkg
//  Purpose  : Shared types and constants for the BCD-to-binary converter.
//             Provides the FSM state encoding, BCD digit limits, the
//             reverse double-dabble adjust constants and default sizing.
//  Revision : 1.0  initial release
// ============================================================================
package bcd_pkg;

  // Default sizing: four digits (0..9999) fit in 14 bits (16384 > 9999).
  localparam int DEF_N_DIGITS = 4;
  localparam int DEF_BIN_W    = 14;

  // Largest legal value of a BCD digit.
  localparam logic [3:0] BCD_MAX    = 4'd9;
  // After a right shift, a digit >= 8 carried a "10" into the bit below,
  // which is worth 8 in binary instead of 5 -- hence subtract 3.
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_VAL    = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // True when a 4-bit code is not a legal decimal digit.
  function automatic logic digit_invalid(input logic [3:0] d);
    return (d > BCD_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_adjust
//  Purpose  : Per-digit correction step of reverse double-dabble.
//             Outputs digit_in - 3 when digit_in >= 8, else digit_in.
//  Ports    : digit_in  [3:0] in   shifted BCD digit
//             digit_out [3:0] out  corrected BCD digit
//  Revision : 1.0  initial release
// ============================================================================
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // digit_in >= 8 guarantees the 4-bit subtract never wraps.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= ADJ_THRESH) begin
      digit_out = digit_in - ADJ_VAL;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_to_binary.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_binary
//  Purpose  : Sequential BCD-to-binary converter, reverse double-dabble,
//             one result bit per clock, with start/busy/done handshake.
//  Ports    : CLK           in   system clock, rising edge
//             RESET_N       in   asynchronous active-low reset
//             START         in   conversion request, sampled in IDLE only
//             BCD_THOUSANDS in   digit 3 (most significant)
//             BCD_HUNDREDS  in   digit 2
//             BCD_TENS      in   digit 1
//             BCD_ONES      in   digit 0
//             BUSY          out  high from acceptance through FINISH
//             DONE          out  one-cycle completion pulse
//             ERROR         out  last request held a digit greater than 9
//             BINARY_OUT    out  result, held until the next completion
//  Revision : 1.0  initial release
// ============================================================================
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = DEF_N_DIGITS,
  parameter int BIN_W    = DEF_BIN_W
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [3:0]       BCD_THOUSANDS,
  input  logic [3:0]       BCD_HUNDREDS,
  input  logic [3:0]       BCD_TENS,
  input  logic [3:0]       BCD_ONES,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR,
  output logic [BIN_W-1:0] BINARY_OUT
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  state_t           state;
  state_t           state_next;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_adj;
  logic [BIN_W-1:0] bin_q;
  logic [BIN_W-1:0] bin_shift;
  logic [CNT_W-1:0] iter_cnt;
  logic             req_err;
  logic [15:0]      digits_in;
  logic             digits_bad;
  logic             last_iter;
  logic             accept;
  logic             finish;
  logic             busy_next;

  assign digits_in  = {BCD_THOUSANDS, BCD_HUNDREDS, BCD_TENS, BCD_ONES};
  assign digits_bad = digit_invalid(BCD_THOUSANDS) | digit_invalid(BCD_HUNDREDS)
                    | digit_invalid(BCD_TENS)      | digit_invalid(BCD_ONES);
  assign last_iter  = (iter_cnt == LAST_ITER);

  // {bcd_q, bin_q} shifted right by one: the BCD LSB drops into the binary MSB.
  assign bcd_shift = {1'b0, bcd_q[BCD_W-1:1]};
  assign bin_shift = {bcd_q[0], bin_q[BIN_W-1:1]};

  generate
    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit_adj
      bcd_digit_adjust u_adj (
        .digit_in  (bcd_shift[4*i +: 4]),
        .digit_out (bcd_adj[4*i +: 4])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (START) begin
          // A bad digit skips conversion entirely and reports at once.
          state_next = digits_bad ? ST_FINISH : ST_CONV;
        end
      end
      ST_CONV: begin
        if (last_iter) begin
          state_next = ST_FINISH;
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode (feeds the registered outputs below)
  // --------------------------------------------------------------------------
  always_comb begin
    accept    = 1'b0;
    finish    = 1'b0;
    busy_next = 1'b0;
    if (state == ST_IDLE && START) begin
      accept = 1'b1;
    end
    if (state == ST_FINISH) begin
      finish = 1'b1;
    end
    if (state_next != ST_IDLE) begin
      busy_next = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bcd_q      <= '0;
      bin_q      <= '0;
      iter_cnt   <= '0;
      req_err    <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERROR      <= 1'b0;
      BINARY_OUT <= '0;
    end else begin
      BUSY <= busy_next;
      DONE <= finish;

      if (accept) begin
        bcd_q    <= BCD_W'(digits_in);
        bin_q    <= '0;
        iter_cnt <= '0;
        req_err  <= digits_bad;
      end else if (state == ST_CONV) begin
        bcd_q    <= bcd_adj;
        bin_q    <= bin_shift;
        iter_cnt <= iter_cnt + CNT_W'(1);
      end

      // Result registers move only on the FINISH cycle, so they line up
      // with the DONE pulse and stay stable otherwise.
      if (finish) begin
        if (req_err) begin
          BINARY_OUT <= '0;
          ERROR      <= 1'b1;
        end else begin
          BINARY_OUT <= bin_q;
          ERROR      <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_binary.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_to_binary
//  Purpose  : Self-checking bench for bcd_to_binary: vector table, hand
//             sequences for the multi-cycle corners, and a scoreboard queue
//             of expected results consumed on every DONE pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_to_binary;

  logic        CLK;
  logic        RESET_N;
  logic        START;
  logic [3:0]  BCD_THOUSANDS;
  logic [3:0]  BCD_HUNDREDS;
  logic [3:0]  BCD_TENS;
  logic [3:0]  BCD_ONES;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic [13:0] BINARY_OUT;

  bcd_to_binary dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .START         (START),
    .BCD_THOUSANDS (BCD_THOUSANDS),
    .BCD_HUNDREDS  (BCD_HUNDREDS),
    .BCD_TENS      (BCD_TENS),
    .BCD_ONES      (BCD_ONES),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .ERROR         (ERROR),
    .BINARY_OUT    (BINARY_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [13:0] bin;
    logic        err;
  } exp_t;

  typedef struct {
    logic [3:0]  d3;
    logic [3:0]  d2;
    logic [3:0]  d1;
    logic [3:0]  d0;
    logic [13:0] bin;
    logic        err;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every DONE pops one expected result.
  always @(negedge CLK) begin
    if (RESET_N && DONE) begin
      done_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got DONE=1 expected DONE=0 (nothing outstanding)");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("binary_out", 32'(BINARY_OUT), 32'(e.bin));
        chk("error", 32'(ERROR), 32'(e.err));
        if (!e.err) chk("bcd_q_zero", 32'(dut.bcd_q), 32'd0);
      end
    end
  end

  task automatic set_digits(input logic [3:0] d3, d2, d1, d0);
    BCD_THOUSANDS = d3;
    BCD_HUNDREDS  = d2;
    BCD_TENS      = d1;
    BCD_ONES      = d0;
  endtask

  // Launch one request, wait for DONE and check the acceptance-to-DONE latency.
  task automatic run_one(input logic [3:0] d3, d2, d1, d0,
                         input logic [13:0] eb, input logic ee, input int el);
    int cyc;
    bit seen;
    @(negedge CLK);
    set_digits(d3, d2, d1, d0);
    START = 1'b1;
    sb.push_back('{bin: eb, err: ee});
    @(posedge CLK);
    #1 START = 1'b0;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) chk("busy_after_accept", 32'(BUSY), 32'd1);
      if (DONE) seen = 1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    else       chk("latency", 32'(cyc - 1), 32'(el));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[10];
    int   d0_snap;
    int   times[3];
    int   n;
    int   cyc;
    bit   seen;

    vecs[0] = '{4'h9, 4'h9, 4'h9, 4'h9, 14'd9999, 1'b0, 15};
    vecs[1] = '{4'h9, 4'h8, 4'h8, 4'h9, 14'd9889, 1'b0, 15};
    vecs[2] = '{4'h0, 4'h0, 4'h0, 4'h1, 14'd1,    1'b0, 15};
    vecs[3] = '{4'h0, 4'h0, 4'h0, 4'h0, 14'd0,    1'b0, 15};
    vecs[4] = '{4'h1, 4'h2, 4'hA, 4'h4, 14'd0,    1'b1, 1};
    vecs[5] = '{4'h0, 4'h0, 4'h4, 4'h2, 14'd42,   1'b0, 15};
    vecs[6] = '{4'h1, 4'h2, 4'h3, 4'h4, 14'd1234, 1'b0, 15};
    vecs[7] = '{4'hF, 4'h0, 4'h0, 4'h0, 14'd0,    1'b1, 1};
    vecs[8] = '{4'h8, 4'h0, 4'h0, 4'h8, 14'd8008, 1'b0, 15};
    vecs[9] = '{4'h0, 4'h0, 4'h0, 4'hB, 14'd0,    1'b1, 1};

    RESET_N = 1'b0;
    START   = 1'b0;
    set_digits(4'h0, 4'h0, 4'h0, 4'h0);
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_error", 32'(ERROR), 32'd0);
    chk("rst_binary_out", 32'(BINARY_OUT), 32'd0);
    RESET_N = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      run_one(vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0,
              vecs[i].bin, vecs[i].err, vecs[i].lat);
    end

    // START during conversion is ignored: one DONE, result 5000.
    @(negedge CLK);
    set_digits(4'h5, 4'h0, 4'h0, 4'h0);
    START = 1'b1;
    sb.push_back('{bin: 14'd5000, err: 1'b0});
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    set_digits(4'h1, 4'h1, 4'h1, 4'h1);
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    set_digits(4'h0, 4'h0, 4'h0, 4'h0);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (DONE) seen = 1;
    end
    if (!seen) chk("ignored_start_done_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #2 d0_snap = done_cnt;
    repeat (25) @(negedge CLK);
    #1 chk("ignored_start_no_extra_done", 32'(done_cnt), 32'(d0_snap));

    // START held high: back-to-back conversions every 16 cycles.
    @(negedge CLK);
    set_digits(4'h0, 4'h1, 4'h2, 4'h3);
    START = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back('{bin: 14'd123, err: 1'b0});
    n   = 0;
    cyc = 0;
    while (n < 3 && cyc < 80) begin
      @(negedge CLK);
      cyc++;
      if (DONE) begin
        times[n] = cyc;
        n++;
        if (n == 3) START = 1'b0;
      end
    end
    START = 1'b0;
    chk("b2b_done_count", 32'(n), 32'd3);
    if (n == 3) begin
      chk("b2b_gap1", 32'(times[1] - times[0]), 32'd16);
      chk("b2b_gap2", 32'(times[2] - times[1]), 32'd16);
    end
    repeat (3) @(negedge CLK);

    // Reset mid-conversion: outputs clear at once, no DONE afterwards.
    @(negedge CLK);
    set_digits(4'h9, 4'h9, 4'h9, 4'h9);
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (7) @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    chk("abort_error", 32'(ERROR), 32'd0);
    chk("abort_binary_out", 32'(BINARY_OUT), 32'd0);
    d0_snap = done_cnt;
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (25) @(negedge CLK);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'(d0_snap));
    chk("abort_idle_busy", 32'(BUSY), 32'd0);

    // Round trip over a spread of values: decimal digits in, same value out.
    for (int v = 0; v < 10000; v += 37) begin
      run_one(4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10),
              14'(v), 1'b0, 15);
    end
    run_one(4'h9, 4'h9, 4'h9, 4'h8, 14'd9998, 1'b0, 15);

    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
